// File: rtl/oram_pkg.sv
// Shared types and constants for the OpenRAM program-store port arbiter.
// Build option ORAM_RDBACK_EN (see oram_port_arbiter) does not affect this package.
package oram_pkg;

    localparam int unsigned ORAM_AW  = 9;
    localparam int unsigned ORAM_DW  = 32;
    localparam logic [11:0] CTRL_OFS = 12'h800;

    typedef enum logic [1:0] {
        SLOT_NONE,
        SLOT_CPU,
        SLOT_WB
    } slot_e;

    typedef enum logic [1:0] {
        IDLE,
        WB_RD,
        WB_ACK
    } wb_state_e;

    // CTRL register read view: bit0 load_mode, bit1 cpu_pending, rest zero.
    function automatic logic [ORAM_DW-1:0] ctrl_rdata(input logic load_mode,
                                                     input logic cpu_pending);
        return {{(ORAM_DW - 2){1'b0}}, cpu_pending, load_mode};
    endfunction

endpackage

// File: rtl/oram_wb_decode.sv
// Wishbone address decode for the program store: 4 KiB window split into RAM words and CTRL.
// Purely combinational; unaffected by ORAM_RDBACK_EN.
module oram_wb_decode
    import oram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic               cyc_i,
    input  logic               stb_i,
    input  logic [31:0]        adr_i,
    output logic               hit_o,
    output logic               ctrl_o,
    output logic [ORAM_AW-1:0] word_o
);

    // Byte lane bits carry no information for word-wide accesses.
    logic unused_adr;
    assign unused_adr = ^adr_i[1:0];

    assign hit_o  = cyc_i & stb_i & (adr_i[31:12] == BASE_ADDR[31:12]);
    assign ctrl_o = |(adr_i[11:0] & CTRL_OFS);
    assign word_o = adr_i[10:2];

endmodule

// File: rtl/oram_port_arbiter.sv
// Shares the single-port OpenRAM program store between core fetch and the Wishbone slave.
// Define ORAM_RDBACK_EN to let Wishbone RAM reads take a slot and return real data.
module oram_port_arbiter
    import oram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int unsigned WB_MAX_WAIT = 4,
    parameter logic        LOAD_RST    = 1'b1
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,

    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_we_i,
    input  logic [3:0]         wbs_sel_i,
    input  logic [31:0]        wbs_adr_i,
    input  logic [31:0]        wbs_dat_i,
    output logic [31:0]        wbs_dat_o,
    output logic               wbs_ack_o,

    input  logic               cpu_req,
    input  logic [ORAM_AW-1:0] cpu_addr,
    output logic               cpu_gnt,
    output logic               cpu_rvalid,
    output logic [ORAM_DW-1:0] cpu_rdata,
    output logic               cpu_rst_o,

    output logic               ram_csb,
    output logic               ram_web,
    output logic [3:0]         ram_wmask,
    output logic [ORAM_AW-1:0] ram_addr,
    output logic [ORAM_DW-1:0] ram_din,
    input  logic [ORAM_DW-1:0] ram_dout
);

    localparam int unsigned      WaitW   = $clog2(WB_MAX_WAIT + 1);
    localparam logic [WaitW-1:0] WaitMax = WaitW'(WB_MAX_WAIT);

    logic               wb_hit;
    logic               wb_ctrl;
    logic [ORAM_AW-1:0] wb_word;

    oram_wb_decode #(
        .BASE_ADDR (BASE_ADDR)
    ) u_decode (
        .cyc_i  (wbs_cyc_i),
        .stb_i  (wbs_stb_i),
        .adr_i  (wbs_adr_i),
        .hit_o  (wb_hit),
        .ctrl_o (wb_ctrl),
        .word_o (wb_word)
    );

    wb_state_e          state_q;
    logic               ack_q;
    logic [ORAM_DW-1:0] dat_q;
    logic               load_mode_q;
    logic [WaitW-1:0]   wait_cnt_q;
    logic               cpu_rvalid_q;

    slot_e              slot;
    logic               wb_accept;
    logic               wb_ram;
    logic               wb_need_slot;
    logic               wb_starved;

    // A held strobe is not re-accepted while its ack is still showing.
    assign wb_accept = wb_hit & (state_q == IDLE) & ~ack_q;
    assign wb_ram    = wb_accept & ~wb_ctrl;

`ifdef ORAM_RDBACK_EN
    assign wb_need_slot = wb_ram;
`else
    assign wb_need_slot = wb_ram & wbs_we_i;
`endif

    assign wb_starved = wb_need_slot & (wait_cnt_q == WaitMax);

    always_comb begin
        slot = SLOT_NONE;
        if (wb_rst_i) begin
            slot = SLOT_NONE;
        end else if (load_mode_q) begin
            if (wb_need_slot) begin
                slot = SLOT_WB;
            end
        end else if (cpu_req && !wb_starved) begin
            slot = SLOT_CPU;
        end else if (wb_need_slot) begin
            slot = SLOT_WB;
        end
    end

    always_comb begin
        ram_csb   = 1'b1;
        ram_web   = 1'b1;
        ram_wmask = 4'h0;
        ram_addr  = '0;
        ram_din   = '0;
        case (slot)
            SLOT_CPU: begin
                ram_csb  = 1'b0;
                ram_addr = cpu_addr;
            end
            SLOT_WB: begin
                ram_csb   = 1'b0;
                ram_web   = ~wbs_we_i;
                ram_wmask = wbs_sel_i;
                ram_addr  = wb_word;
                ram_din   = wbs_dat_i;
            end
            default: ;
        endcase
    end

    assign cpu_gnt    = (slot == SLOT_CPU);
    assign cpu_rvalid = cpu_rvalid_q;
    assign cpu_rdata  = cpu_rvalid_q ? ram_dout : '0;
    assign cpu_rst_o  = wb_rst_i | load_mode_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = dat_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= IDLE;
            ack_q        <= 1'b0;
            dat_q        <= '0;
            load_mode_q  <= LOAD_RST;
            wait_cnt_q   <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= (slot == SLOT_CPU);
            ack_q        <= 1'b0;

            if (slot == SLOT_WB) begin
                wait_cnt_q <= '0;
            end else if (wb_need_slot && (wait_cnt_q != WaitMax)) begin
                wait_cnt_q <= wait_cnt_q + WaitW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (wb_accept) begin
                        if (wb_ctrl) begin
                            if (wbs_we_i) begin
                                load_mode_q <= wbs_dat_i[0];
                            end
                            dat_q   <= wbs_we_i ? '0 : ctrl_rdata(load_mode_q, cpu_req);
                            ack_q   <= 1'b1;
                            state_q <= WB_ACK;
                        end else if (slot == SLOT_WB) begin
                            dat_q <= '0;
                            if (wbs_we_i) begin
                                ack_q   <= 1'b1;
                                state_q <= WB_ACK;
                            end else begin
                                state_q <= WB_RD;
                            end
                        end else if (!wb_need_slot) begin
                            // RAM read without readback support: answer zero, no slot.
                            dat_q   <= '0;
                            ack_q   <= 1'b1;
                            state_q <= WB_ACK;
                        end
                    end
                end
                WB_RD: begin
                    dat_q   <= ram_dout;
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                end
                WB_ACK: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oram_port_arbiter.sv
// Directed bench for oram_port_arbiter with a behavioural 512x32 RAM model.
// Expected values follow ORAM_RDBACK_EN when the bench is built with it.
module tb_oram_port_arbiter;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_dat_o;
    logic        wbs_ack_o;
    logic        cpu_req;
    logic [8:0]  cpu_addr;
    logic        cpu_gnt;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        cpu_rst_o;
    logic        ram_csb;
    logic        ram_web;
    logic [3:0]  ram_wmask;
    logic [8:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    always #5 wb_clk_i = ~wb_clk_i;

    oram_port_arbiter dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_dat_o  (wbs_dat_o),
        .wbs_ack_o  (wbs_ack_o),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_gnt    (cpu_gnt),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_rst_o  (cpu_rst_o),
        .ram_csb    (ram_csb),
        .ram_web    (ram_web),
        .ram_wmask  (ram_wmask),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    logic [31:0] mem [512];

    initial begin
        for (int i = 0; i < 512; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end

    always @(posedge wb_clk_i) begin
        if (!ram_csb) begin
            if (!ram_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
                end
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pre(input int i);
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic wb_drop();
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
    endtask

    task automatic wb_start(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel);
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        wbs_we_i  = we;
        wbs_adr_i = adr;
        wbs_dat_i = dat;
        wbs_sel_i = sel;
    endtask

    // Full access, bounded to 8 cycles; lat counts cycles from issue to ack.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, output logic acked, output int lat,
                             output logic [31:0] rdata);
        wb_start(we, adr, dat, sel);
        acked = 1'b0;
        lat   = 0;
        rdata = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                acked = 1'b1;
                lat   = i;
                rdata = wbs_dat_o;
                break;
            end
        end
        wb_drop();
        step();
    endtask

    localparam logic [31:0] Ctrl = 32'h3000_0800;

    logic        acked;
    int          lat;
    logic [31:0] rd;
    int          exp_rb_lat;
    logic [31:0] exp_rb_dat;

    initial begin
`ifdef ORAM_RDBACK_EN
        exp_rb_lat = 2;
        exp_rb_dat = 32'hDEAD_BEEF;
`else
        exp_rb_lat = 1;
        exp_rb_dat = 32'h0;
`endif
        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = 4'h0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        cpu_req   = 1'b1;
        cpu_addr  = '0;

        // Reset
        @(negedge wb_clk_i);
        check("rst_cpu_gnt", cpu_gnt, 1'b0);
        check("rst_ram_csb_req", ram_csb, 1'b1);
        step();
        step();
        wb_rst_i = 1'b0;
        cpu_req  = 1'b0;
        @(negedge wb_clk_i);
        check("reset_cpu_rst", cpu_rst_o, 1'b1);
        check("reset_ram_csb", ram_csb, 1'b1);
        check("reset_ram_web", ram_web, 1'b1);
        check("reset_ack", wbs_ack_o, 1'b0);
        check("reset_dat", wbs_dat_o, 32'h0);
        check("reset_rvalid", cpu_rvalid, 1'b0);
        check("reset_rdata", cpu_rdata, 32'h0);
        step();

        wb_access(1'b0, Ctrl, 32'h0, 4'hF, acked, lat, rd);
        check("ctrl_rd_ack", acked, 1'b1);
        check("ctrl_rd_lat", lat, 1);
        check("ctrl_rd_dat", rd, 32'h1);

        // Out-of-window address must never ack
        wb_access(1'b1, 32'h3000_1800, 32'h0, 4'hF, acked, lat, rd);
        check("miss_no_ack", acked, 1'b0);
        check("miss_load_mode", cpu_rst_o, 1'b1);

        // Load mode keeps the core off the RAM
        cpu_req  = 1'b1;
        cpu_addr = 9'd1;
        @(negedge wb_clk_i);
        check("load_gnt_blocked", cpu_gnt, 1'b0);
        check("load_csb_idle", ram_csb, 1'b1);
        step();
        wb_access(1'b0, Ctrl, 32'h0, 4'hF, acked, lat, rd);
        check("ctrl_pending", rd, 32'h3);
        cpu_req = 1'b0;

        // Program load write
        wb_start(1'b1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF);
        @(negedge wb_clk_i);
        check("wr_csb", ram_csb, 1'b0);
        check("wr_web", ram_web, 1'b0);
        check("wr_addr", ram_addr, 9'd4);
        check("wr_wmask", ram_wmask, 4'hF);
        check("wr_din", ram_din, 32'hDEAD_BEEF);
        check("wr_ack_early", wbs_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("wr_ack", wbs_ack_o, 1'b1);
        wb_drop();
        step();
        check("wr_mem4", mem[4], 32'hDEAD_BEEF);

        wb_access(1'b0, 32'h3000_0010, 32'h0, 4'hF, acked, lat, rd);
        check("rb_ack", acked, 1'b1);
        check("rb_lat", lat, exp_rb_lat);
        check("rb_dat", rd, exp_rb_dat);

        wb_access(1'b1, Ctrl, 32'h0, 4'hF, acked, lat, rd);
        check("clr_ack", acked, 1'b1);
        check("clr_cpu_rst", cpu_rst_o, 1'b0);

        // Back-to-back fetch stream
        for (int k = 0; k < 8; k++) begin
            cpu_req  = 1'b1;
            cpu_addr = 9'(k);
            @(negedge wb_clk_i);
            check($sformatf("stream_gnt%0d", k), cpu_gnt, 1'b1);
            check($sformatf("stream_addr%0d", k), ram_addr, 9'(k));
            if (k > 0) begin
                check($sformatf("stream_rvalid%0d", k), cpu_rvalid, 1'b1);
                check($sformatf("stream_rdata%0d", k), cpu_rdata,
                      (k == 5) ? 32'hDEAD_BEEF : pre(k - 1));
            end
            step();
        end
        cpu_req = 1'b0;
        @(negedge wb_clk_i);
        check("stream_gnt_end", cpu_gnt, 1'b0);
        check("stream_rvalid7", cpu_rvalid, 1'b1);
        check("stream_rdata7", cpu_rdata, pre(7));
        step();
        @(negedge wb_clk_i);
        check("stream_rvalid_off", cpu_rvalid, 1'b0);
        step();

        // Starvation: WB write wins after WB_MAX_WAIT denied cycles
        cpu_req  = 1'b1;
        cpu_addr = 9'd0;
        wb_start(1'b1, 32'h3000_0020, 32'h5555_AAAA, 4'hF);
        for (int c = 0; c < 6; c++) begin
            @(negedge wb_clk_i);
            check($sformatf("starve_gnt%0d", c), cpu_gnt, 32'(c != 4));
            check($sformatf("starve_ack%0d", c), wbs_ack_o, 32'(c == 5));
            if (c == 5) check("starve_rvalid_gap", cpu_rvalid, 1'b0);
        end
        wb_drop();
        step();
        cpu_req = 1'b0;
        check("starve_mem8", mem[8], 32'h5555_AAAA);

`ifndef ORAM_RDBACK_EN
        // Without readback, a WB read never takes the core's slot
        cpu_req = 1'b1;
        wb_start(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        for (int c = 0; c < 2; c++) begin
            @(negedge wb_clk_i);
            check($sformatf("nostall_gnt%0d", c), cpu_gnt, 1'b1);
            check($sformatf("nostall_ack%0d", c), wbs_ack_o, 32'(c == 1));
        end
        wb_drop();
        step();
        cpu_req = 1'b0;
`endif

        // Byte write to word 3, lane 1 only
        wb_start(1'b1, 32'h3000_000C, 32'h0000_AB00, 4'b0010);
        @(negedge wb_clk_i);
        check("byte_wmask", ram_wmask, 4'b0010);
        check("byte_addr", ram_addr, 9'd3);
        @(negedge wb_clk_i);
        check("byte_ack", wbs_ack_o, 1'b1);
        wb_drop();
        step();
        cpu_req  = 1'b1;
        cpu_addr = 9'd3;
        step();
        cpu_req = 1'b0;
        @(negedge wb_clk_i);
        check("byte_rdata", cpu_rdata, 32'hC0DE_AB03);
        step();

        // Fetch and CTRL write in the same cycle
        cpu_req  = 1'b1;
        cpu_addr = 9'd6;
        wb_start(1'b1, Ctrl, 32'h1, 4'hF);
        @(negedge wb_clk_i);
        check("sim_gnt", cpu_gnt, 1'b1);
        check("sim_ack_early", wbs_ack_o, 1'b0);
        @(negedge wb_clk_i);
        check("sim_rvalid", cpu_rvalid, 1'b1);
        check("sim_rdata", cpu_rdata, pre(6));
        check("sim_ack", wbs_ack_o, 1'b1);
        check("sim_gnt_blocked", cpu_gnt, 1'b0);
        check("sim_cpu_rst", cpu_rst_o, 1'b1);
        wb_drop();
        cpu_req = 1'b0;
        step();

        wb_access(1'b1, Ctrl, 32'h0, 4'hF, acked, lat, rd);
        check("pre_rst_cpu_rst", cpu_rst_o, 1'b0);

        // Reset in the slot cycle drops the write
        wb_start(1'b1, 32'h3000_0024, 32'h1234_5678, 4'hF);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        check("rstmid_csb", ram_csb, 1'b1);
        step();
        wb_rst_i = 1'b0;
        wb_drop();
        @(negedge wb_clk_i);
        check("rstmid_ack0", wbs_ack_o, 1'b0);
        check("rstmid_load_mode", cpu_rst_o, 1'b1);
        step();
        @(negedge wb_clk_i);
        check("rstmid_ack1", wbs_ack_o, 1'b0);
        check("rstmid_mem9", mem[9], pre(9));
        step();

`ifdef ORAM_RDBACK_EN
        // Reset while the read is in WB_RD
        wb_start(1'b0, 32'h3000_0010, 32'h0, 4'hF);
        @(negedge wb_clk_i);
        check("rdrst_csb", ram_csb, 1'b0);
        step();
        wb_rst_i = 1'b1;
        wb_drop();
        @(negedge wb_clk_i);
        check("rdrst_ack0", wbs_ack_o, 1'b0);
        step();
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rdrst_ack1", wbs_ack_o, 1'b0);
        check("rdrst_dat", wbs_dat_o, 32'h0);
        step();
`endif

        wb_access(1'b0, Ctrl, 32'h0, 4'hF, acked, lat, rd);
        check("post_rst_ctrl", rd, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
